// File: rtl/hmc_mem_link_tx_init_pkg.sv
// ---------------------------------------------------------------------------
// hmc_mem_tx_pkg
// Shared types and constants for the HMC device-side transmit link sequencer.
//   - tx_state_e : sequencer state encoding (also exported on init_state)
//   - TS1_PREFIX : upper 12 bits of every TS1 training word
//   - NULL_WORD  : 16-bit NULL flit pattern
//   - LANE_SEED  : per-lane scrambler seeds, used only when the design is
//                  built with HMC_MEM_TX_SCRAMBLE_EN defined
// ---------------------------------------------------------------------------
package hmc_mem_tx_pkg;

   typedef enum logic [2:0] {
      ST_RESET    = 3'd0,
      ST_WAIT_PWR = 3'd1,
      ST_NULL1    = 3'd2,
      ST_TS1      = 3'd3,
      ST_NULL2    = 3'd4,
      ST_ACTIVE   = 3'd5,
      ST_SLEEP    = 3'd6,
      ST_ERROR    = 3'd7
   } tx_state_e;

   localparam logic [11:0] TS1_PREFIX = 12'hF0C;
   localparam logic [15:0] NULL_WORD  = 16'h0000;

   localparam int NUM_SEEDS = 8;
   localparam logic [14:0] LANE_SEED [0:NUM_SEEDS-1] = '{
      15'h4D56, 15'h47FF, 15'h75B8, 15'h1E18,
      15'h2E10, 15'h3EB2, 15'h4302, 15'h1380
   };

   // One TS1 word: fixed prefix followed by the 4-bit sequence number.
   function automatic logic [15:0] ts1_word(input logic [3:0] seq);
      return {TS1_PREFIX, seq};
   endfunction

endpackage

// File: rtl/hmc_mem_link_tx_init_if.sv
// ---------------------------------------------------------------------------
// hmc_mem_link_tx_init_if
// Flit handshake between the responder's flit source and the TX sequencer.
//   tx_flit_data  : flit payload (DWIDTH bits)
//   tx_flit_valid : payload valid
//   tx_flit_ready : sequencer accepts the payload this cycle
// master = flit source, slave = sequencer.
// ---------------------------------------------------------------------------
interface hmc_mem_link_tx_init_if #(
   parameter int DWIDTH = 256
);
   logic [DWIDTH-1:0] tx_flit_data;
   logic              tx_flit_valid;
   logic              tx_flit_ready;

   modport master (output tx_flit_data, output tx_flit_valid, input tx_flit_ready);
   modport slave  (input tx_flit_data, input tx_flit_valid, output tx_flit_ready);
endinterface

// File: rtl/hmc_mem_link_tx_init_lane_scrambler.sv
// ---------------------------------------------------------------------------
// hmc_mem_lane_scrambler
// One lane of the TX scrambler: 15-bit LFSR x^15+x^14+1, stepped LANE_W
// times per advancing cycle, producing a LANE_W-bit keystream.
// Only instantiated when HMC_MEM_TX_SCRAMBLE_EN is defined.
//   hmc_clk, hmc_rst : clock, synchronous active-high reset (loads SEED)
//   load             : restart from SEED this cycle (mask uses the seed)
//   adv              : commit the LANE_W-step advance
//   mask             : keystream for the current cycle, bit 0 first
// ---------------------------------------------------------------------------
module hmc_mem_lane_scrambler #(
   parameter int          LANE_W = 32,
   parameter logic [14:0] SEED   = 15'h4D56
) (
   input  logic              hmc_clk,
   input  logic              hmc_rst,
   input  logic              load,
   input  logic              adv,
   output logic [LANE_W-1:0] mask
);
   logic [14:0] lfsr_reg;
   logic [14:0] lfsr_next;
   logic [14:0] state_v;

   // Unrolled serial LFSR: each step emits the MSB, then shifts in the tap XOR.
   always_comb begin
      state_v = load ? SEED : lfsr_reg;
      mask    = '0;
      for (int i = 0; i < LANE_W; i++) begin
         mask[i] = state_v[14];
         state_v = {state_v[13:0], state_v[14] ^ state_v[13]};
      end
      lfsr_next = state_v;
   end

   always_ff @(posedge hmc_clk) begin
      if (hmc_rst) begin
         lfsr_reg <= SEED;
      end else if (adv) begin
         lfsr_reg <= lfsr_next;
      end else if (load) begin
         lfsr_reg <= SEED;
      end
   end
endmodule

// File: rtl/hmc_mem_link_tx_init.sv
// ---------------------------------------------------------------------------
// hmc_mem_link_tx_init
// Device-side HMC transmit link sequencer: NULL -> TS1 training -> NULL ->
// ACTIVE flit transmission, with SLEEP/retrain and fatal-error handling.
// Ports:
//   hmc_clk, hmc_rst      : clock, synchronous active-high reset
//   p_rst_n               : host reset, low forces RESET (highest priority)
//   lxrxps                : host power-state request
//   rx_ts1_seen           : device RX locked on host TS1
//   flit (slave modport)  : tx_flit_data / tx_flit_valid / tx_flit_ready
//   phy_data_rx_phy2link  : registered word stream toward the controller
//   lxtxps, ferr_n        : TX power state, fatal error (active-low)
//   init_state            : current state encoding
// Build option: HMC_MEM_TX_SCRAMBLE_EN adds per-lane LFSR scrambling.
// All outputs are registered alongside the state, so an output always
// reflects the state it is presented in.
// ---------------------------------------------------------------------------
module hmc_mem_link_tx_init
   import hmc_mem_tx_pkg::*;
#(
   parameter int DWIDTH         = 256,
   parameter int NUM_LANES      = 8,
   parameter int NULL_CYCLES    = 55,
   parameter int TS1_MIN_CYCLES = 32,
   parameter int TS1_TIMEOUT    = 4096,
   parameter int NULL2_CYCLES   = 16
) (
   input  logic                  hmc_clk,
   input  logic                  hmc_rst,
   input  logic                  p_rst_n,
   input  logic                  lxrxps,
   input  logic                  rx_ts1_seen,
   hmc_mem_link_tx_init_if.slave flit,
   output logic [DWIDTH-1:0]     phy_data_rx_phy2link,
   output logic                  lxtxps,
   output logic                  ferr_n,
   output logic [2:0]            init_state
);
   localparam int LANE_W  = DWIDTH / NUM_LANES;
   localparam int WPL     = LANE_W / 16;          // TS1 words per lane per cycle
   localparam int CNT_MAX = (TS1_TIMEOUT > NULL_CYCLES) ?
                            ((TS1_TIMEOUT > NULL2_CYCLES) ? TS1_TIMEOUT : NULL2_CYCLES) :
                            ((NULL_CYCLES > NULL2_CYCLES) ? NULL_CYCLES : NULL2_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] NULL1_LAST = CNT_W'(NULL_CYCLES - 1);
   localparam logic [CNT_W-1:0] NULL2_LAST = CNT_W'(NULL2_CYCLES - 1);
   localparam logic [CNT_W-1:0] TS1_MIN    = CNT_W'(TS1_MIN_CYCLES);
   localparam logic [CNT_W-1:0] TS1_LAST   = CNT_W'(TS1_TIMEOUT - 1);

   tx_state_e         state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [3:0]        seq_reg, seq_next, seq_base;
   logic [DWIDTH-1:0] data_reg, data_next, plain_next, ts1_flit;
   logic              lxtxps_reg, ferr_n_reg, ready_reg;
   logic              send_flit;

   // A flit handshaken while ready=1 is always transmitted next cycle, even
   // when lxrxps drops in that same cycle; a host reset discards it.
   assign send_flit = ready_reg & flit.tx_flit_valid & p_rst_n;

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_RESET:    if (p_rst_n) state_next = ST_WAIT_PWR;
         ST_WAIT_PWR: if (lxrxps) state_next = ST_NULL1;
         ST_NULL1:    if (cnt_reg >= NULL1_LAST) state_next = ST_TS1;
         ST_TS1: begin
            // Lock exit is checked first so it wins over the timeout.
            if (rx_ts1_seen && cnt_reg >= TS1_MIN) state_next = ST_NULL2;
            else if (cnt_reg >= TS1_LAST)          state_next = ST_ERROR;
         end
         ST_NULL2:    if (cnt_reg >= NULL2_LAST) state_next = ST_ACTIVE;
         ST_ACTIVE:   if (!lxrxps) state_next = ST_SLEEP;
         ST_SLEEP:    if (lxrxps) state_next = ST_NULL1;
         ST_ERROR:    state_next = ST_ERROR;
         default:     state_next = ST_RESET;
      endcase
      if (!p_rst_n) state_next = ST_RESET;
   end

   // Counter restarts on every state change and saturates at all-ones.
   assign cnt_next = (state_next != state_reg) ? '0 :
                     ((cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1);

   // TS1 sequence runs across words of a lane and restarts on TS1 entry.
   assign seq_base = (state_reg == ST_TS1) ? seq_reg : 4'd0;
   assign seq_next = (state_next == ST_TS1) ? seq_base + 4'(WPL) : 4'd0;

   genvar gi;
   generate
      for (gi = 0; gi < DWIDTH / 16; gi++) begin : g_ts1
         assign ts1_flit[gi*16 +: 16] = ts1_word(seq_base + 4'(gi % WPL));
      end
   endgenerate

   always_comb begin
      plain_next = {(DWIDTH/16){NULL_WORD}};
      if (send_flit)                  plain_next = flit.tx_flit_data;
      else if (state_next == ST_TS1)  plain_next = ts1_flit;
   end

`ifdef HMC_MEM_TX_SCRAMBLE_EN
   logic              scr_load, scr_adv;
   logic [DWIDTH-1:0] scr_mask;

   assign scr_load = (state_next == ST_NULL1) && (state_reg != ST_NULL1);
   assign scr_adv  = send_flit || state_next == ST_NULL1 || state_next == ST_TS1 ||
                     state_next == ST_NULL2 || state_next == ST_ACTIVE;

   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_scr
         hmc_mem_lane_scrambler #(
            .LANE_W (LANE_W),
            .SEED   (LANE_SEED[gi % NUM_SEEDS])
         ) u_scr (
            .hmc_clk (hmc_clk),
            .hmc_rst (hmc_rst),
            .load    (scr_load),
            .adv     (scr_adv),
            .mask    (scr_mask[gi*LANE_W +: LANE_W])
         );
      end
   endgenerate

   // Non-running states keep the line at zero rather than sending keystream.
   assign data_next = scr_adv ? (plain_next ^ scr_mask) : '0;
`else
   assign data_next = plain_next;
`endif

   always_ff @(posedge hmc_clk) begin
      if (hmc_rst) begin
         state_reg  <= ST_RESET;
         cnt_reg    <= '0;
         seq_reg    <= '0;
         data_reg   <= '0;
         lxtxps_reg <= 1'b0;
         ferr_n_reg <= 1'b1;
         ready_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         seq_reg    <= seq_next;
         data_reg   <= data_next;
         ready_reg  <= (state_next == ST_ACTIVE);
         ferr_n_reg <= (state_next != ST_ERROR);
         // lxtxps rises on entry to NULL1 and is otherwise held (incl. ERROR).
         if (state_next == ST_RESET || state_next == ST_SLEEP)
            lxtxps_reg <= 1'b0;
         else if (state_next == ST_NULL1 && state_reg != ST_NULL1)
            lxtxps_reg <= 1'b1;
      end
   end

   assign phy_data_rx_phy2link = data_reg;
   assign lxtxps               = lxtxps_reg;
   assign ferr_n               = ferr_n_reg;
   assign flit.tx_flit_ready   = ready_reg;
   assign init_state           = state_reg;

endmodule

// File: tb/tb_hmc_mem_link_tx_init.sv
// ---------------------------------------------------------------------------
// tb_hmc_mem_link_tx_init
// Self-checking bench for hmc_mem_link_tx_init: randomized flit traffic,
// TS1 lock timing and lxrxps glitches, compared cycle by cycle against a
// phase/age reference model. Honors HMC_MEM_TX_SCRAMBLE_EN.
// ---------------------------------------------------------------------------
module tb_hmc_mem_link_tx_init;
   localparam int DW   = 256;
   localparam int NL   = 8;
   localparam int LW   = DW / NL;
   localparam int WPL  = LW / 16;
   localparam int N1   = 55;
   localparam int TMIN = 32;
   localparam int TTO  = 4096;
   localparam int N2   = 16;

   logic          hmc_clk = 1'b0;
   logic          hmc_rst, p_rst_n, lxrxps, rx_ts1_seen;
   logic [DW-1:0] phy;
   logic          lxtxps, ferr_n;
   logic [2:0]    init_state;

   hmc_mem_link_tx_init_if #(.DWIDTH(DW)) flit_if();

   hmc_mem_link_tx_init #(
      .DWIDTH(DW), .NUM_LANES(NL), .NULL_CYCLES(N1),
      .TS1_MIN_CYCLES(TMIN), .TS1_TIMEOUT(TTO), .NULL2_CYCLES(N2)
   ) dut (
      .hmc_clk              (hmc_clk),
      .hmc_rst              (hmc_rst),
      .p_rst_n              (p_rst_n),
      .lxrxps               (lxrxps),
      .rx_ts1_seen          (rx_ts1_seen),
      .flit                 (flit_if),
      .phy_data_rx_phy2link (phy),
      .lxtxps               (lxtxps),
      .ferr_n               (ferr_n),
      .init_state           (init_state)
   );

   always #5 hmc_clk = ~hmc_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: phase number, cycle index within the phase, outputs.
   int            m_phase, m_age, flits_sent;
   logic          m_lxtxps, m_ready, m_ferr_n;
   logic [DW-1:0] m_data;

   // Stimulus controls.
   int ts1_from   = -1;   // TS1 cycle index from which rx_ts1_seen is high
   bit auto_flit  = 0;
   bit lx_glitch  = 0;
   int cnt_null   = 0;
   int cnt_ts1    = 0;
   int scr_left   = 1;

   task automatic model_reset();
      m_phase = 0; m_age = 0; m_lxtxps = 0; m_ready = 0; m_ferr_n = 1; m_data = '0;
   endtask

   task automatic model_step();
      int   np;
      logic pass;
      pass = m_ready && flit_if.tx_flit_valid && p_rst_n;
      np   = m_phase;
      case (m_phase)
         0: if (p_rst_n) np = 1;
         1: if (lxrxps) np = 2;
         2: if (m_age == N1 - 1) np = 3;
         3: if (rx_ts1_seen && m_age >= TMIN) np = 4;
            else if (m_age == TTO - 1) np = 7;
         4: if (m_age == N2 - 1) np = 5;
         5: if (!lxrxps) np = 6;
         6: if (lxrxps) np = 2;
         default: ;
      endcase
      if (!p_rst_n) np = 0;
      if (np == 2 && m_phase != 2) m_lxtxps = 1;
      else if (np == 0 || np == 6) m_lxtxps = 0;
      m_age    = (np == m_phase) ? m_age + 1 : 0;
      m_phase  = np;
      m_ready  = (np == 5);
      m_ferr_n = (np != 7);
      if (pass) begin
         m_data = flit_if.tx_flit_data;
         flits_sent++;
         $display("flit %0d sent data=%h", flits_sent, m_data);
      end else if (np == 3) begin
         for (int w = 0; w < DW / 16; w++)
            m_data[w*16 +: 16] = {12'hF0C, 4'((m_age * WPL + w % WPL) % 16)};
      end else begin
         m_data = '0;
      end
   endtask

`ifdef HMC_MEM_TX_SCRAMBLE_EN
   // Keystream of lane 0 for NULL1 cycle c, generated bit-serially from seed.
   function automatic logic [LW-1:0] ref_ks(input int c);
      logic [14:0] s;
      logic [LW-1:0] r;
      s = 15'h4D56;
      r = '0;
      for (int i = 0; i < (c + 1) * LW; i++) begin
         r[i % LW] = s[14];
         s = {s[13:0], s[14] ^ s[13]};
      end
      return r;
   endfunction
`endif

   task automatic drive();
      rx_ts1_seen = (ts1_from >= 0 && m_phase == 3 && m_age >= ts1_from);
      if (lx_glitch) lxrxps = (m_phase >= 2 && m_phase <= 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (auto_flit) begin
         flit_if.tx_flit_valid = ($urandom_range(0, 3) != 0);
         for (int w = 0; w < DW / 32; w++) flit_if.tx_flit_data[w*32 +: 32] = $urandom;
      end
   endtask

   task automatic cyc();
      @(posedge hmc_clk);
      if (hmc_rst) model_reset(); else model_step();
      #1;
      check_eq("state",  DW'(init_state), DW'(m_phase));
      check_eq("lxtxps", DW'(lxtxps), DW'(m_lxtxps));
      check_eq("ferr_n", DW'(ferr_n), DW'(m_ferr_n));
      check_eq("ready",  DW'(flit_if.tx_flit_ready), DW'(m_ready));
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("data", phy, m_data);
`else
      if (m_phase == 2 && scr_left > 0 && m_age < 4) begin
         check_eq("scr_lane0", DW'(phy[LW-1:0]), DW'(ref_ks(m_age)));
         if (m_age == 3) scr_left = 0;
      end
`endif
      if (init_state == 3'd2) cnt_null++;
      if (init_state == 3'd3) cnt_ts1++;
      drive();
   endtask

   task automatic run_until(input int ph, input int budget, input string tag);
      int n = 0;
      while (m_phase != ph && n < budget) begin
         cyc();
         n++;
      end
      check_eq(tag, DW'(init_state), DW'(ph));
   endtask

   initial begin
      logic [DW-1:0] fa, fb;
      int k;
      hmc_rst = 1; p_rst_n = 0; lxrxps = 0; rx_ts1_seen = 0;
      flit_if.tx_flit_valid = 0; flit_if.tx_flit_data = '0;
      model_reset();
      flits_sent = 0;
      repeat (3) cyc();
      hmc_rst = 0; p_rst_n = 1;
      repeat (4) cyc();

      // First training: lock from TS1 cycle 10, held until the minimum.
      lxrxps = 1; cnt_null = 0; cnt_ts1 = 0; ts1_from = 10;
      run_until(3, 200, "reach_ts1");
      check_eq("null1_len", DW'(cnt_null), DW'(N1));
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("ts1_c0", DW'(phy[31:0]), DW'(32'hF0C1F0C0));
      cyc();
      check_eq("ts1_c1", DW'(phy[31:0]), DW'(32'hF0C3F0C2));
`endif
      run_until(4, 200, "reach_null2");
      check_eq("ts1_len_min", DW'(cnt_ts1), DW'(TMIN + 1));
      run_until(5, 100, "reach_active");

      // Directed A, idle, B flits.
      for (int w = 0; w < DW / 32; w++) begin
         fa[w*32 +: 32] = $urandom;
         fb[w*32 +: 32] = $urandom;
      end
      flit_if.tx_flit_valid = 1; flit_if.tx_flit_data = fa; cyc();
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("flit_a", phy, fa);
`endif
      flit_if.tx_flit_valid = 0; cyc();
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("flit_gap", phy, '0);
`endif
      flit_if.tx_flit_valid = 1; flit_if.tx_flit_data = fb; cyc();
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("flit_b", phy, fb);
`endif
      auto_flit = 1;
      repeat (40) cyc();

      // Sleep, then full retrain with lock arriving late (cycle 40).
      lxrxps = 0; cyc();
      check_eq("sleep_ready", DW'(flit_if.tx_flit_ready), DW'(0));
      repeat (5) cyc();
      lxrxps = 1; cnt_null = 0; cnt_ts1 = 0; ts1_from = 40;
      run_until(3, 200, "retrain_ts1");
      check_eq("retrain_null1_len", DW'(cnt_null), DW'(N1));
      run_until(4, 200, "retrain_null2");
      check_eq("ts1_len_late", DW'(cnt_ts1), DW'(41));
      run_until(5, 100, "retrain_active");
      repeat (20) cyc();

      // Host reset in the middle of TS1, with lxrxps glitches during training.
      lxrxps = 0;
      run_until(6, 10, "sleep2");
      lxrxps = 1; lx_glitch = 1; ts1_from = $urandom_range(0, 60);
      run_until(3, 200, "glitch_ts1");
      k = $urandom_range(3, 20);
      repeat (k) cyc();
      p_rst_n = 0; cyc();
      check_eq("prst_state",  DW'(init_state), DW'(0));
      check_eq("prst_data",   phy, '0);
      check_eq("prst_lxtxps", DW'(lxtxps), DW'(0));
      p_rst_n = 1;
      run_until(3, 200, "reinit_ts1");
`ifndef HMC_MEM_TX_SCRAMBLE_EN
      check_eq("reinit_ts1_c0", DW'(phy[31:0]), DW'(32'hF0C1F0C0));
`endif
      run_until(5, 300, "reinit_active");
      lx_glitch = 0;
      repeat (30) cyc();

      // TS1 timeout into ERROR, which ignores lxrxps until host reset.
      lxrxps = 0;
      run_until(6, 10, "sleep3");
      lxrxps = 1; ts1_from = -1; cnt_ts1 = 0; auto_flit = 0; flit_if.tx_flit_valid = 0;
      run_until(7, 5000, "reach_error");
      check_eq("ts1_len_timeout", DW'(cnt_ts1), DW'(TTO));
      check_eq("error_ferr", DW'(ferr_n), DW'(0));
      repeat (10) begin
         lxrxps = 1'($urandom_range(0, 1));
         cyc();
      end
      p_rst_n = 0; cyc();
      check_eq("error_exit_ferr",  DW'(ferr_n), DW'(1));
      check_eq("error_exit_state", DW'(init_state), DW'(0));
      p_rst_n = 1; lxrxps = 1;
      repeat (5) cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
